// File: rtl/echo_pkg.sv
// ---------------------------------------------------------------------------
// echo_pkg
// Shared definitions for the echo accelerator bundle interface. The core-side
// controller (echo_xfer_ctrl) and the accelerator import this package so both
// ends agree on register width, bundle size and the bundle layout.
//   VREG_W       : vector register width in bits
//   NREGS        : registers carried per bundle
//   vreg_t       : one vector register
//   bundle_t     : NREGS registers, slot k at [k]
//   xfer_state_e : transfer controller FSM states
// ---------------------------------------------------------------------------
package echo_pkg;

   localparam int VREG_W = 512;
   localparam int NREGS  = 16;

   typedef logic [VREG_W-1:0] vreg_t;
   typedef logic [NREGS-1:0][VREG_W-1:0] bundle_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GATHER  = 3'd1,
      ST_SEND    = 3'd2,
      ST_WAIT    = 3'd3,
      ST_SCATTER = 3'd4,
      ST_DONE    = 3'd5
   } xfer_state_e;

endpackage

// File: rtl/echo_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// echo_xfer_ctrl
// Core-side initiator for the echo accelerator. On start it reads NREGS
// vector registers (SRC_BASE..) one per cycle into a bundle buffer, offers the
// bundle on the request channel, accepts the response bundle into the same
// buffer and writes it back to DST_BASE.. one register per cycle.
//
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   start_i             single-cycle start request (honoured only in IDLE)
//   busy_o              high whenever the FSM is not in IDLE
//   done_o              one-cycle pulse after the last write-back
//   rf_re_o/rf_raddr_o  register-file read port; rf_rdata_i arrives 1 cycle later
//   rf_we_o/rf_waddr_o/rf_wdata_o  register-file write port
//   acc_req_*           request bundle channel (controller -> accelerator)
//   acc_resp_*          response bundle channel (accelerator -> controller)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The request side holds valid and data stable until ready; the
// response side raises ready only in WAIT, so an early response simply stays
// pending on the accelerator side until then.
// ---------------------------------------------------------------------------
module echo_xfer_ctrl #(
   parameter int VREG_W   = echo_pkg::VREG_W,
   parameter int NREGS    = echo_pkg::NREGS,
   parameter int SRC_BASE = 0,
   parameter int DST_BASE = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    rf_re_o,
   output logic [4:0]              rf_raddr_o,
   input  logic [VREG_W-1:0]       rf_rdata_i,
   output logic                    rf_we_o,
   output logic [4:0]              rf_waddr_o,
   output logic [VREG_W-1:0]       rf_wdata_o,
   output logic                    acc_req_valid_o,
   input  logic                    acc_req_ready_i,
   output logic [NREGS*VREG_W-1:0] acc_req_data_o,
   input  logic                    acc_resp_valid_i,
   output logic                    acc_resp_ready_o,
   input  logic [NREGS*VREG_W-1:0] acc_resp_data_i
);

   import echo_pkg::*;

   localparam int         IDX_W     = $clog2(NREGS);
   localparam logic [4:0] SRC_B     = 5'(SRC_BASE);
   localparam logic [4:0] DST_B     = 5'(DST_BASE);
   localparam logic [4:0] CNT_GLAST = 5'(NREGS);      // GATHER runs 0..NREGS
   localparam logic [4:0] CNT_SLAST = 5'(NREGS - 1);  // SCATTER runs 0..NREGS-1

   typedef logic [NREGS-1:0][VREG_W-1:0] buf_t;

   // Register windows must fit the 32-entry file; the 5-bit counter must be
   // able to hold NREGS.
   if ((SRC_BASE + NREGS > 32) || (DST_BASE + NREGS > 32) ||
       (NREGS < 2) || (NREGS > 31)) begin : g_bad_cfg
      $error("echo_xfer_ctrl: illegal SRC_BASE/DST_BASE/NREGS combination");
   end

   xfer_state_e      state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   buf_t             buf_q, buf_d;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
      end
   end

   // The bundle buffer is the request payload; it is only meaningful while
   // acc_req_valid_o is high.
   assign acc_req_data_o = buf_q;

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      buf_d            = buf_q;
      busy_o           = (state_q != ST_IDLE);
      done_o           = 1'b0;
      rf_re_o          = 1'b0;
      rf_raddr_o       = '0;
      rf_we_o          = 1'b0;
      rf_waddr_o       = '0;
      rf_wdata_o       = '0;
      acc_req_valid_o  = 1'b0;
      acc_resp_ready_o = 1'b0;
      // Read data lags the read address by one cycle, so the slot being
      // filled is one behind the counter.
      rd_idx           = IDX_W'(cnt_q - 5'd1);
      wr_idx           = IDX_W'(cnt_q);

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_GATHER;
               cnt_d   = '0;
            end
         end

         ST_GATHER: begin
            if (cnt_q < CNT_GLAST) begin
               rf_re_o    = 1'b1;
               rf_raddr_o = SRC_B + cnt_q;
            end
            if (cnt_q != 5'd0) begin
               buf_d[rd_idx] = rf_rdata_i;
            end
            if (cnt_q == CNT_GLAST) begin
               state_d = ST_SEND;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end

         ST_SEND: begin
            acc_req_valid_o = 1'b1;
            if (acc_req_ready_i) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end
         end

         ST_WAIT: begin
            acc_resp_ready_o = 1'b1;
            if (acc_resp_valid_i) begin
               buf_d   = acc_resp_data_i;
               state_d = ST_SCATTER;
               cnt_d   = '0;
            end
         end

         ST_SCATTER: begin
            rf_we_o    = 1'b1;
            rf_waddr_o = DST_B + cnt_q;
            rf_wdata_o = buf_q[wr_idx];
            if (cnt_q == CNT_SLAST) begin
               state_d = ST_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end

         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_echo_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_echo_xfer_ctrl
// Bench for echo_xfer_ctrl: register-file and accelerator models live in the
// driver task, a table of transfer scenarios is applied in a loop, and the
// reset-abort case is a hand-written sequence. Cycle numbers are counted from
// the edge that samples start_i (cycle 0).
// ---------------------------------------------------------------------------
module tb_echo_xfer_ctrl;

   import echo_pkg::*;

   localparam int W = 512;
   localparam int N = 16;

   typedef struct {
      int stall;     // cycles acc_req_ready_i held low in SEND
      int delay;     // cycles acc_resp_valid_i held low in WAIT
      bit inv;       // responder returns inverted data
      bit restart;   // extra start pulses during GATHER and SCATTER
      bit early;     // response raised during GATHER with a fixed pattern
      int exp_done;  // cycle in which done_o must pulse
   } scen_t;

   logic           clk;
   logic           rst_n;
   logic           start_i;
   logic           busy_o;
   logic           done_o;
   logic           rf_re_o;
   logic [4:0]     rf_raddr_o;
   logic [W-1:0]   rf_rdata_i;
   logic           rf_we_o;
   logic [4:0]     rf_waddr_o;
   logic [W-1:0]   rf_wdata_o;
   logic           acc_req_valid_o;
   logic           acc_req_ready_i;
   logic [N*W-1:0] acc_req_data_o;
   logic           acc_resp_valid_i;
   logic           acc_resp_ready_o;
   logic [N*W-1:0] acc_resp_data_i;

   int             n_tests;
   int             n_fail;
   logic [W-1:0]   rf [32];
   logic [W-1:0]   exp_out [N];
   logic [N*W-1:0] early_flat;
   logic [N*W-1:0] req_cap;
   scen_t          tbl [5];

   echo_xfer_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start_i          (start_i),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .rf_re_o          (rf_re_o),
      .rf_raddr_o       (rf_raddr_o),
      .rf_rdata_i       (rf_rdata_i),
      .rf_we_o          (rf_we_o),
      .rf_waddr_o       (rf_waddr_o),
      .rf_wdata_o       (rf_wdata_o),
      .acc_req_valid_o  (acc_req_valid_o),
      .acc_req_ready_i  (acc_req_ready_i),
      .acc_req_data_o   (acc_req_data_o),
      .acc_resp_valid_i (acc_resp_valid_i),
      .acc_resp_ready_o (acc_resp_ready_o),
      .acc_resp_data_i  (acc_resp_data_i)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic logic [W-1:0] pre_val(input int k);
      return {16{32'hA000_0000 + 32'(k)}};
   endfunction

   function automatic logic [W-1:0] sentinel(input int k);
      return {16{32'hDEAD_0000 + 32'(k)}};
   endfunction

   function automatic logic [W-1:0] early_val(input int k);
      return {16{32'h5A5A_0000 + 32'(k)}};
   endfunction

   function automatic logic [15:0] ctrl_now();
      return {busy_o, done_o, rf_re_o, rf_raddr_o, rf_we_o, rf_waddr_o,
              acc_req_valid_o, acc_resp_ready_o};
   endfunction

   task automatic check(input string name, input int cyc,
                        input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   task automatic preload();
      for (int k = 0; k < N; k++) begin
         rf[k]      = pre_val(k);
         rf[N + k]  = sentinel(k);
      end
   endtask

   // ---------------- driver + per-cycle checker ----------------
   task automatic run_xfer(input scen_t s, input bit rst_mid);
      int          w0, s0;
      int          send_cnt, wait_cnt, done_cyc, n_rd, n_wr, n_dn, bad;
      bit          prev_re, resp_taken, e_re, e_we, e_rv, e_rr, e_done, e_busy;
      logic [4:0]  prev_raddr, e_raddr, e_waddr;
      logic [15:0] e_ctrl;

      preload();
      for (int k = 0; k < N; k++)
         exp_out[k] = s.early ? early_val(k) : (s.inv ? ~pre_val(k) : pre_val(k));
      w0 = 19 + s.stall;
      s0 = w0 + s.delay + 1;
      send_cnt = 0; wait_cnt = 0; done_cyc = -1;
      n_rd = 0; n_wr = 0; n_dn = 0;
      prev_re = 1'b0; prev_raddr = '0; resp_taken = 1'b0;
      req_cap = '0;

      @(negedge clk);
      start_i          = 1'b1;
      acc_req_ready_i  = 1'b0;
      acc_resp_valid_i = 1'b0;
      @(posedge clk);  // cycle 0: start sampled

      for (int rel = 1; rel <= s0 + 17; rel++) begin
         @(negedge clk);
         start_i = s.restart && (rel == 5 || rel == 25);

         e_re    = (rel >= 1) && (rel <= N);
         e_raddr = e_re ? 5'(rel - 1) : 5'd0;
         e_rv    = (rel >= 18) && (rel <= 18 + s.stall);
         e_rr    = (rel >= w0) && (rel <= w0 + s.delay);
         e_we    = (rel >= s0) && (rel < s0 + N);
         e_waddr = e_we ? 5'(N + rel - s0) : 5'd0;
         e_done  = (rel == s0 + N);
         e_busy  = (rel >= 1) && (rel <= s0 + N);
         e_ctrl  = {e_busy, e_done, e_re, e_raddr, e_we, e_waddr, e_rv, e_rr};
         check("ctrl{busy,done,re,raddr,we,waddr,rqv,rsr}", rel, ctrl_now(), e_ctrl);
         if (e_we) check("rf_wdata", rel, rf_wdata_o, exp_out[rel - s0]);
         if (e_rv) begin
            bad = -1;
            for (int k = 0; k < N; k++)
               if (bad < 0 && acc_req_data_o[k*W +: W] !== pre_val(k)) bad = k;
            check("req_data_bad_slot_plus1", rel, W'(bad + 1), '0);
         end

         // register-file model
         if (rf_re_o) n_rd++;
         if (rf_we_o) begin
            rf[rf_waddr_o] = rf_wdata_o;
            n_wr++;
         end
         if (done_o) begin
            n_dn++;
            done_cyc = rel;
         end
         rf_rdata_i = prev_re ? rf[prev_raddr] : {16{$urandom}};
         prev_re    = rf_re_o;
         prev_raddr = rf_raddr_o;

         // accelerator model
         acc_req_ready_i = acc_req_valid_o && (send_cnt >= s.stall);
         if (acc_req_valid_o) begin
            if (acc_req_ready_i) req_cap = acc_req_data_o;
            send_cnt++;
         end
         acc_resp_valid_i = !resp_taken &&
                            (s.early ? (rel >= 5)
                                     : (acc_resp_ready_o && (wait_cnt >= s.delay)));
         acc_resp_data_i  = s.early ? early_flat : (s.inv ? ~req_cap : req_cap);
         if (acc_resp_ready_o) wait_cnt++;
         if (acc_resp_ready_o && acc_resp_valid_i) resp_taken = 1'b1;

         if (rst_mid && rel == s0 + 7) break;
      end

      if (!rst_mid) begin
         check("n_reads", 0, W'(n_rd), W'(16));
         check("n_writes", 0, W'(n_wr), W'(16));
         check("n_done", 0, W'(n_dn), W'(1));
         check("done_cycle", 0, W'(done_cyc), W'(s.exp_done));
         for (int k = 0; k < N; k++)
            check("rf_dst_contents", N + k, rf[N + k], exp_out[k]);
      end else begin
         // 8th write (v23) commits on this edge, then reset lands.
         @(posedge clk);
         #1 rst_n = 1'b0;
         #1;
         check("rst_ctrl_zero", 0, W'(ctrl_now()), '0);
         check("rst_wdata_zero", 0, rf_wdata_o, '0);
         check("rst_reqdata_nonzero", 0, W'(|acc_req_data_o), '0);
         start_i = 1'b0; acc_req_ready_i = 1'b0; acc_resp_valid_i = 1'b0;
         for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_hold_ctrl_zero", i, W'(ctrl_now()), '0);
            if (rf_we_o) rf[rf_waddr_o] = rf_wdata_o;
            if (done_o) n_dn++;
         end
         rst_n = 1'b1;
         check("rst_n_done", 0, W'(n_dn), '0);
         for (int k = 0; k < 8; k++)
            check("rst_written_part", N + k, rf[N + k], exp_out[k]);
         for (int k = 8; k < N; k++)
            check("rst_unwritten_part", N + k, rf[N + k], sentinel(k));
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n = 1'b0; start_i = 1'b0; rf_rdata_i = '0;
      acc_req_ready_i = 1'b0; acc_resp_valid_i = 1'b0; acc_resp_data_i = '0;
      for (int k = 0; k < N; k++) early_flat[k*W +: W] = early_val(k);

      //            stall delay inv restart early done
      tbl[0] = '{0,    0,    0,  0,      0,    36};
      tbl[1] = '{5,    0,    0,  0,      0,    41};
      tbl[2] = '{0,    10,   1,  0,      0,    46};
      tbl[3] = '{0,    0,    0,  1,      0,    36};
      tbl[4] = '{0,    0,    0,  0,      1,    36};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctrl", 0, W'(ctrl_now()), '0);
      check("reset_wdata", 0, rf_wdata_o, '0);
      check("reset_reqdata_nonzero", 0, W'(|acc_req_data_o), '0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_ctrl", 0, W'(ctrl_now()), '0);

      for (int i = 0; i < 5; i++) run_xfer(tbl[i], 1'b0);

      // Abort on the 8th write-back, then a clean transfer must follow.
      run_xfer(tbl[0], 1'b1);
      run_xfer(tbl[0], 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/echo_xfer_ctrl.md
Name: echo_xfer_ctrl

Overview:
Core-side initiator for the echo accelerator bundle interface.
- On start, reads v0–v15 from the vector register file one register per cycle and assembles the 16x512 request bundle.
- Hands the bundle to the accelerator over a valid/ready request channel, then accepts the 16x512 response bundle over a valid/ready response channel.
- Writes the response back into v16–v31, one register per cycle.
- Sits between the vproc_core register-file ports and the echo accelerator.

Parameters:
VREG_W, 512, vector register width in bits
NREGS, 16, registers per bundle
SRC_BASE, 0, first source register index
DST_BASE, 16, first destination register index; elaboration error if DST_BASE+NREGS>32 or SRC_BASE+NREGS>32

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  single-cycle start request
busy_o  output  1  high whenever the FSM is not in IDLE
done_o  output  1  one-cycle pulse when write-back completes
rf_re_o  output  1  register-file read enable
rf_raddr_o  output  5  register-file read address
rf_rdata_i  input  VREG_W  read data, valid exactly 1 cycle after rf_re_o
rf_we_o  output  1  register-file write enable
rf_waddr_o  output  5  register-file write address
rf_wdata_o  output  VREG_W  register-file write data
acc_req_valid_o  output  1  request bundle valid
acc_req_ready_i  input  1  accelerator accepts the request
acc_req_data_o  output  NREGS*VREG_W  request bundle, slot k = v(SRC_BASE+k)
acc_resp_valid_i  input  1  response bundle valid
acc_resp_ready_o  output  1  controller accepts the response
acc_resp_data_i  input  NREGS*VREG_W  response bundle, slot k goes to v(DST_BASE+k)

Behaviour:
- Reset (async assert, sync release): state IDLE, counter 0, bundle buffer cleared to 0. All outputs drive 0: busy_o, done_o, rf_re_o, rf_we_o, both valid/ready outputs, both addresses, rf_wdata_o, acc_req_data_o.
- FSM states: IDLE, GATHER, SEND, WAIT, SCATTER, DONE.
- IDLE: start_i=1 moves to GATHER with counter=0. In every other state start_i is ignored; no queuing.
- GATHER runs for counter 0..NREGS:
  - When counter<NREGS: rf_re_o=1, rf_raddr_o=SRC_BASE+counter.
  - When counter>=1: rf_rdata_i is captured into buffer slot counter-1.
  - After counter==NREGS it moves to SEND. GATHER therefore lasts NREGS+1 cycles.
- SEND: acc_req_valid_o=1 and acc_req_data_o=buffer, held stable until acc_req_ready_i=1. On that handshake cycle it moves to WAIT. No timeout; the controller waits indefinitely.
- acc_req_data_o always reflects the buffer. It is meaningful only while acc_req_valid_o=1.
- WAIT: acc_resp_ready_o=1. On acc_resp_valid_i=1, acc_resp_data_i is captured into the buffer (the buffer is reused) and the FSM moves to SCATTER with counter=0. acc_resp_ready_o is 0 in all other states, so a response presented early stays pending until WAIT.
- SCATTER: for NREGS cycles, rf_we_o=1, rf_waddr_o=DST_BASE+counter, rf_wdata_o=buffer slot counter. After the last write it moves to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Timing with zero-wait accelerator (start sampled high at cycle 0):
  - Reads in cycles 1–16.
  - SEND at cycle 18.
  - WAIT at cycle 19.
  - Writes in cycles 20–35.
  - done_o at cycle 36.
  - busy_o high in cycles 1–36.
- Every stall cycle on acc_req_ready_i or acc_resp_valid_i adds one cycle.
- Counter is 5 bits and never wraps: it is bounded by NREGS and reset to 0 on each state entry.
- Reset asserted mid-operation aborts immediately. No partial write continues, and no done_o is issued.

Decomposition:
- Package echo_pkg holds:
  - VREG_W and NREGS constants
  - typedef vreg_t = logic [VREG_W-1:0]
  - typedef bundle_t = logic [NREGS-1:0][VREG_W-1:0]
  - the xfer_state_e enum
- The accelerator (echo) imports the same package so both ends agree on the bundle type.
- Single flat module; no sub-module is warranted.

Test Plan:
- Preload vK=32'hA000_0000+K replicated across 512 bits; identity responder, ready/valid always high; pulse start -> reads addr 0..15 in cycles 1–16, one request handshake, writes addr 16..31 with data equal to v0..v15, done_o at cycle 36, busy_o low at 37.
- Same as above but acc_req_ready_i held low for 5 cycles in SEND -> acc_req_valid_o stays high and acc_req_data_o stays unchanged throughout the stall; done_o at cycle 41.
- Responder returns bitwise-inverted data after 10 cycles -> v16..v31 hold ~v0..~v15; acc_resp_ready_o high only in WAIT; done_o at cycle 46.
- start_i pulsed again during GATHER and SCATTER -> ignored; exactly one done_o, exactly 16 reads and 16 writes.
- rst_n asserted on the 8th SCATTER write -> all outputs 0 immediately; v24..v31 left unwritten; no done_o; a new start afterwards completes normally.
- acc_resp_valid_i raised during GATHER -> not accepted (acc_resp_ready_o=0); accepted on the first WAIT cycle, and that data is what gets written back.
